// File: rtl/xload_bus_master.sv
// Host byte-stream loader: parses W/R/H/G frames and issues single-word
// transactions on the native CPU memory bus while the CPU is held in reset.
module xload_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          HOLD_AT_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold,
  output logic        busy
);

  localparam logic [7:0]  OP_W     = 8'h57;
  localparam logic [7:0]  OP_R     = 8'h52;
  localparam logic [7:0]  OP_H     = 8'h48;
  localparam logic [7:0]  OP_G     = 8'h47;
  localparam logic [7:0]  ACK      = 8'h06;
  localparam logic [7:0]  NAK      = 8'h15;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARGS, BUS, RESP} state_t;

  state_t      state, state_next;
  logic        armed;
  logic [7:0]  opcode;
  logic [2:0]  arg_cnt;
  logic [31:0] addr_sr, data_sr;
  logic [31:0] addr_shift, data_shift;
  logic [15:0] tmo_cnt;
  logic [39:0] resp_buf;
  logic [2:0]  resp_left;
  logic        accept, last_arg, out_fire;
  logic        start_bus, load_resp;
  logic [39:0] load_buf;
  logic [2:0]  load_len;

  // armed keeps in_ready low on the reset cycle itself
  assign in_ready   = armed & ((state == IDLE) | (state == ARGS));
  assign accept     = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign busy       = (state != IDLE);
  assign mem_instr  = 1'b0;
  assign addr_shift = {in_data, addr_sr[31:8]};
  assign data_shift = {in_data, data_sr[31:8]};
  assign last_arg   = (opcode == OP_W) ? (arg_cnt == 3'd7) : (arg_cnt == 3'd3);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_bus  = 1'b0;
    load_resp  = 1'b0;
    load_buf   = {32'h0, NAK};
    load_len   = 3'd1;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (in_data == OP_W || in_data == OP_R) begin
            state_next = ARGS;
          end else begin
            state_next = RESP;
            load_resp  = 1'b1;
            if (in_data == OP_H || in_data == OP_G) load_buf = {32'h0, ACK};
          end
        end
      end
      ARGS: begin
        if (accept && last_arg) begin
          if (cpu_hold) begin
            state_next = BUS;
            start_bus  = 1'b1;
          end else begin
            state_next = RESP;
            load_resp  = 1'b1;
          end
        end
      end
      BUS: begin
        // completion takes priority over a timeout on the same edge
        if (mem_ready) begin
          state_next = RESP;
          load_resp  = 1'b1;
          if (opcode == OP_R) begin
            load_buf = {mem_rdata, ACK};
            load_len = 3'd5;
          end else begin
            load_buf = {32'h0, ACK};
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = RESP;
          load_resp  = 1'b1;
        end
      end
      RESP: begin
        if (out_fire && resp_left == 3'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed     <= 1'b0;
      opcode    <= 8'h00;
      arg_cnt   <= 3'd0;
      addr_sr   <= 32'h0;
      data_sr   <= 32'h0;
      tmo_cnt   <= 16'h0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      resp_buf  <= 40'h0;
      resp_left <= 3'd0;
      cpu_hold  <= HOLD_AT_RESET;
    end else begin
      armed <= 1'b1;
      if (state == IDLE && accept) begin
        opcode  <= in_data;
        arg_cnt <= 3'd0;
        if (in_data == OP_H)      cpu_hold <= 1'b1;
        else if (in_data == OP_G) cpu_hold <= 1'b0;
      end
      if (state == ARGS && accept) begin
        arg_cnt <= arg_cnt + 3'd1;
        if (arg_cnt < 3'd4) addr_sr <= addr_shift;
        else                data_sr <= data_shift;
      end
      // the final argument byte is still on in_data, so take it from the shift path
      if (start_bus) begin
        mem_valid <= 1'b1;
        tmo_cnt   <= 16'h0;
        if (opcode == OP_W) begin
          mem_addr  <= {addr_sr[31:2], 2'b00};
          mem_wdata <= data_shift;
          mem_wstrb <= 4'hF;
        end else begin
          mem_addr  <= {addr_shift[31:2], 2'b00};
          mem_wstrb <= 4'h0;
        end
      end
      if (state == BUS) begin
        tmo_cnt <= tmo_cnt + 16'd1;
        if (state_next != BUS) mem_valid <= 1'b0;
      end
      if (load_resp) begin
        out_valid <= 1'b1;
        out_data  <= load_buf[7:0];
        resp_buf  <= load_buf;
        resp_left <= load_len;
      end else if (out_fire) begin
        if (resp_left == 3'd1) begin
          out_valid <= 1'b0;
        end else begin
          resp_buf  <= {8'h00, resp_buf[39:8]};
          out_data  <= resp_buf[15:8];
          resp_left <= resp_left - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xload_bus_master.sv
// Scoreboard bench for xload_bus_master: frame-level reference model, memory
// responder with programmable latency, decoupled output and bus monitors.
module tb_xload_bus_master;

  localparam int TMO = 8;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        in_ready, out_valid, mem_valid, mem_instr, cpu_hold, busy;
  logic [7:0]  out_data;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  xload_bus_master #(.TIMEOUT_CYCLES(TMO), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cycles;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [7:0]  exp_out[$];
  logic [31:0] sram[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];
  int          n_vec = 0;
  int          n_miss = 0;
  int          resp_delay = 1;
  bit          bp_hold = 1'b0;
  bit          model_hold = 1'b1;

  function automatic logic [31:0] readSram(input logic [31:0] a);
    if (sram.exists(a)) return sram[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] readModel(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    n_vec++;
    n_miss++;
    $display("[TB] FAIL %s: event occurred, required none", name);
  endtask

  // Memory responder: ready after resp_delay cycles of mem_valid, junk ready while idle
  int rsp_cnt = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (!resetn || !mem_valid) begin
      rsp_cnt = 0;
      if (resetn) begin
        mem_ready = ($urandom_range(0, 5) == 0);
        mem_rdata = $urandom;
      end
    end else begin
      if (rsp_cnt == resp_delay) begin
        mem_ready = 1'b1;
        if (mem_wstrb == 4'hF) sram[mem_addr] = mem_wdata;
        else                   mem_rdata = readSram(mem_addr);
      end
      rsp_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Output monitor
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_out.size() == 0) flagFail("out_unexpected_byte");
      else checkOutput("out_byte", 64'(out_data), 64'(exp_out.pop_front()));
    end
  end

  // Bus monitor
  bus_exp_t cur;
  bit       have_cur = 1'b0;
  logic     prev_v = 1'b0;
  int       vcyc = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_v   = 1'b0;
      have_cur = 1'b0;
      vcyc     = 0;
    end else begin
      if (mem_valid && !prev_v) begin
        vcyc = 0;
        if (exp_bus.size() == 0) begin
          have_cur = 1'b0;
          flagFail("bus_unexpected_cycle");
        end else begin
          cur = exp_bus.pop_front();
          have_cur = 1'b1;
          checkOutput("mem_addr", 64'(mem_addr), 64'(cur.addr));
          checkOutput("mem_wstrb", 64'(mem_wstrb), 64'(cur.wstrb));
          if (cur.wstrb == 4'hF) checkOutput("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end
      end else if (mem_valid && have_cur) begin
        checkOutput("mem_addr_stable", 64'(mem_addr), 64'(cur.addr));
      end
      if (mem_valid) vcyc++;
      if (!mem_valid && prev_v && have_cur) begin
        checkOutput("mem_valid_cycles", 64'(vcyc), 64'(cur.cycles));
        have_cur = 1'b0;
      end
      prev_v = mem_valid;
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) flagFail("in_ready_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference model: decides the reply and bus cycle of a frame from its rules
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input int delay);
    logic [31:0] wa;
    logic [31:0] rd;
    bus_exp_t    be;
    bit          ok;
    wa = {addr[31:2], 2'b00};
    ok = (delay < TMO);
    resp_delay = delay;
    be.addr = wa;
    be.wdata = data;
    be.cycles = ok ? delay + 1 : TMO;
    case (op)
      8'h57: begin
        if (!model_hold) exp_out.push_back(NAK);
        else begin
          be.wstrb = 4'hF;
          exp_bus.push_back(be);
          if (ok) begin
            model_mem[wa] = data;
            exp_out.push_back(ACK);
          end else exp_out.push_back(NAK);
        end
        sendByte(op);
        for (int i = 0; i < 4; i++) sendByte(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) sendByte(data[8*i +: 8]);
      end
      8'h52: begin
        if (!model_hold) exp_out.push_back(NAK);
        else begin
          be.wstrb = 4'h0;
          exp_bus.push_back(be);
          if (ok) begin
            rd = readModel(wa);
            exp_out.push_back(ACK);
            for (int i = 0; i < 4; i++) exp_out.push_back(rd[8*i +: 8]);
          end else exp_out.push_back(NAK);
        end
        sendByte(op);
        for (int i = 0; i < 4; i++) sendByte(addr[8*i +: 8]);
      end
      8'h48: begin model_hold = 1'b1; exp_out.push_back(ACK); sendByte(op); end
      8'h47: begin model_hold = 1'b0; exp_out.push_back(ACK); sendByte(op); end
      default: begin exp_out.push_back(NAK); sendByte(op); end
    endcase
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    while (exp_out.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) flagFail({name, "_reply_timeout"});
    @(negedge clk);
    @(negedge clk);
    checkOutput({name, "_busy"}, 64'(busy), 64'(0));
    checkOutput({name, "_out_valid"}, 64'(out_valid), 64'(0));
    checkOutput({name, "_cpu_hold"}, 64'(cpu_hold), 64'(model_hold));
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    int          d;
    int          guard;
    int          r;

    #1 resetn = 1'b0;
    #11;
    checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("rst_mem_valid", 64'(mem_valid), 64'(0));
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_cpu_hold", 64'(cpu_hold), 64'(1));
    checkOutput("mem_instr", 64'(mem_instr), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 64'(in_ready), 64'(1));

    $display("[TB] directed write");
    applyStimulus(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 1);
    waitIdle("write");

    $display("[TB] directed read");
    sram[32'h10] = 32'h1122_3344;
    model_mem[32'h10] = 32'h1122_3344;
    applyStimulus(8'h52, 32'h0000_0012, 32'h0, 1);
    waitIdle("read");

    $display("[TB] timeout and completion on the limit edge");
    applyStimulus(8'h52, 32'h0000_0020, 32'h0, 255);
    waitIdle("timeout");
    applyStimulus(8'h57, 32'h0000_0024, 32'hCAFE_F00D, TMO - 1);
    waitIdle("limit_write");
    applyStimulus(8'h52, 32'h0000_0024, 32'h0, TMO - 1);
    waitIdle("limit_read");

    $display("[TB] hold control");
    applyStimulus(8'h47, 32'h0, 32'h0, 0);
    waitIdle("release");
    applyStimulus(8'h57, 32'h0000_0030, 32'h1234_5678, 0);
    waitIdle("write_released");
    applyStimulus(8'h48, 32'h0, 32'h0, 0);
    waitIdle("hold");

    $display("[TB] backpressure");
    bp_hold = 1'b1;
    applyStimulus(8'h52, 32'h0000_0010, 32'h0, 2);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) flagFail("bp_out_valid_timeout");
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
      checkOutput("bp_out_data", 64'(out_data), 64'(ACK));
      checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
    end
    bp_hold = 1'b0;
    waitIdle("backpressure");
    applyStimulus(8'hAA, 32'h0, 32'h0, 0);
    waitIdle("unknown_op");

    $display("[TB] reset during bus cycle");
    applyStimulus(8'h52, 32'h0000_0040, 32'h0, 255);
    guard = 0;
    while (!mem_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) flagFail("midrst_mem_valid_timeout");
    #2 resetn = 1'b0;
    #1;
    checkOutput("midrst_mem_valid", 64'(mem_valid), 64'(0));
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_in_ready", 64'(in_ready), 64'(0));
    exp_out.delete();
    exp_bus.delete();
    model_hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(8'h57, 32'h0000_0044, 32'hA5A5_5A5A, 3);
    waitIdle("post_reset_write");
    applyStimulus(8'h52, 32'h0000_0044, 32'h0, 0);
    waitIdle("post_reset_read");

    $display("[TB] random frames");
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      a = 32'h100 + $urandom_range(0, 63);
      d = ($urandom_range(0, 8) == 8) ? 255 : $urandom_range(0, TMO - 1);
      if (r <= 3)      op = 8'h57;
      else if (r <= 6) op = 8'h52;
      else if (r == 7) op = 8'h48;
      else if (r == 8) op = (model_hold && $urandom_range(0, 1) == 0) ? 8'h47 : 8'h48;
      else begin
        do op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52 || op == 8'h48 || op == 8'h47);
      end
      applyStimulus(op, a, $urandom, d);
      waitIdle("random");
    end

    checkOutput("out_queue_drained", 64'(exp_out.size()), 64'(0));
    checkOutput("bus_queue_drained", 64'(exp_bus.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
